// File: rtl/fifo_tx_serializer.sv
// FIFO drain stage: pops one word per frame and shifts it out as
// start(0), WID data bits LSB-first, [even parity], stop(1).
// Ports:
//   clk, rst (async active-low)
//   empty_i, rdata_i : FIFO read side (data valid the cycle after rd_o)
//   rd_o             : one-cycle FIFO read strobe
//   tx_o             : registered serial line, idles high
//   busy_o           : high outside IDLE
//   frame_done_o     : pulse on the last cycle of each stop bit
// Option: define FIFO_TX_SERIALIZER_PARITY_EN to add a parity bit.
module fifo_tx_serializer #(
  parameter int WID     = 8,
  parameter int CLK_DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           empty_i,
  input  logic [WID-1:0] rdata_i,
  output logic           rd_o,
  output logic           tx_o,
  output logic           busy_o,
  output logic           frame_done_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (WID > 1) ? $clog2(WID) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PEN  =
    DIV_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WID - 1);
  // With a one-cycle bit, the stop bit's first cycle is its last.
  localparam logic ONE_CYC = (CLK_DIV == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state;
  logic [WID-1:0]   r_shift;
  logic [CNT_W-1:0] r_bit;
  logic [DIV_W-1:0] r_div;
  logic             r_tx;
  logic             r_rd;
  logic             r_busy;
  logic             r_done;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
  logic             r_par;
`endif

  logic             w_bit_end;
  logic [WID-1:0]   w_shift_nx;

  assign w_bit_end  = (r_div == DIV_LAST);
  assign w_shift_nx = r_shift >> 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
      r_tx    <= 1'b1;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_rd   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!empty_i) begin
            r_state <= S_FETCH;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_shift <= rdata_i;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
          r_par   <= ^rdata_i;
`endif
          r_bit   <= '0;
          r_div   <= '0;
          r_tx    <= 1'b0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_div   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_div   <= '0;
            r_shift <= w_shift_nx;
            if (r_bit == BIT_LAST) begin
              r_bit   <= '0;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
              r_tx    <= r_par;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_done  <= ONE_CYC;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= w_shift_nx[0];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_div   <= '0;
            r_tx    <= 1'b1;
            r_done  <= ONE_CYC;
            r_state <= S_STOP;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_div <= '0;
            if (!empty_i) begin
              r_state <= S_FETCH;
              r_rd    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_div  <= r_div + 1'b1;
            // raise the pulse so it lands on the final stop cycle
            r_done <= (r_div == DIV_PEN);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign rd_o         = r_rd;
  assign tx_o         = r_tx;
  assign busy_o       = r_busy;
  assign frame_done_o = r_done;

endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
- Downstream drain stage for the synchronous FIFO.
- Pops one word at a time from the FIFO read port and shifts it out on a single-wire asynchronous serial line.
- Frame format: start bit (0), WID data bits LSB-first, stop bit (1).
- Bit period is set by a clock divider. Back-to-back frames are issued while the FIFO stays non-empty.

Parameters:
- WID, 8, data word width; must match the FIFO data width.
- CLK_DIV, 4, clock cycles per serial bit; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous active-low reset.
- empty_i  input  1  FIFO empty flag.
- rdata_i  input  WID  FIFO read data; valid the cycle after rd_o is high.
- rd_o  output  1  FIFO read strobe; high for exactly one cycle per word.
- tx_o  output  1  serial line, registered; idles high.
- busy_o  output  1  high whenever the FSM is not in IDLE.
- frame_done_o  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_o=1, rd_o=0, busy_o=0, frame_done_o=0, shift register=0, bit counter=0, divider counter=0.
- Reset mid-frame aborts the frame immediately. The word in flight is lost and no additional rd_o is issued.
- States: IDLE, FETCH, LOAD, START, DATA, STOP (PARITY added when PARITY_EN is defined).
- IDLE -> FETCH when empty_i=0; otherwise stay in IDLE.
- FETCH: rd_o=1 for this single cycle; always -> LOAD next cycle.
- LOAD: capture rdata_i into the shift register; -> START.
- rd_o is never high in any state other than FETCH. The block never reads an empty FIFO because FETCH is entered only with empty_i=0.
- START: tx_o=0 for CLK_DIV cycles; -> DATA.
- DATA:
  - tx_o = shift register bit 0, held for CLK_DIV cycles.
  - Then shift right and increment the bit counter.
  - After WID bits -> STOP (or PARITY).
- STOP: tx_o=1 for CLK_DIV cycles. frame_done_o=1 on the final cycle.
  - Then -> FETCH if empty_i=0 at that cycle, else -> IDLE.
- Divider counter counts 0..CLK_DIV-1 and resets on every bit boundary. With CLK_DIV=1 each bit lasts one cycle.
- Counter widths are $clog2 of the bound, minimum 1 bit.
- tx_o is registered: its value changes on the clock edge that enters the new bit's first cycle.
- Latency: empty_i falling sampled at edge n -> rd_o high in cycle n+1 -> LOAD in n+2 -> tx_o=0 from n+3.
- Frame length: (WID+2)*CLK_DIV cycles on the line (plus CLK_DIV with parity).
- Minimum gap between consecutive frames: 2 cycles (FETCH, LOAD) with tx_o=1.
- empty_i toggling during START/DATA/STOP/PARITY has no effect.
- busy_o=1 in FETCH through STOP inclusive.

Optional Feature:
- Macro: FIFO_TX_SERIALIZER_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx_o = even parity (XOR of the WID captured data bits) for CLK_DIV cycles.
  - Frame becomes (WID+3)*CLK_DIV cycles.
- Undefined: no PARITY state, no parity logic synthesised; DATA -> STOP directly.

Test Plan:
- Reset check: hold rst=0 with empty_i=0 -> tx_o=1, rd_o=0, busy_o=0 throughout. Release rst -> rd_o high exactly one cycle, 1 cycle after release sampling.
- Single word, WID=8, CLK_DIV=4: empty_i=0 for one word, rdata_i=8'hA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles (40 cycles total), then frame_done_o pulses once on the 40th cycle.
- Back-to-back: FIFO holds 8'h00 then 8'hFF, empty_i stays 0 -> two rd_o pulses 42 cycles apart; second frame data bits all 1; exactly 2 idle-high cycles between the frames.
- Empty mid-frame: empty_i rises during DATA of 8'h3C -> frame completes unchanged; FSM returns to IDLE, busy_o=0, no further rd_o.
- Async reset mid-frame: assert rst=0 during the 3rd data bit -> tx_o=1 and busy_o=0 immediately, without waiting for a clock edge. After release with empty_i=1 -> no rd_o, line idle.
- Parity (macro defined), rdata_i=8'h07 -> a parity bit of 1 follows bit7 for 4 cycles; frame is 44 cycles. Repeat with 8'hA5 -> parity bit 0.
